multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Multi-cycle sequencer for the 32-bit MIPS datapath. Steps each instruction through
//  FETCH/DECODE/EXECUTE/MEM/WRITEBACK, one state per clock. Drives the shared memory,
//  ALU, register file and PC enables. Handles lw, sw, R-type, lui, xori, beq, bne, j and jal.
// PARAMETERS
//  MEM_WAIT_MAX  8  max consecutive cycles a memory state waits for mem_ready before bus_err
// PORTS
//  clk          in   1  system clock; all state changes on posedge
//  reset        in   1  asynchronous, active-high; forces IDLE and all outputs to 0
//  opcode       in   6  IR[31:26]; sampled in DECODE only
//  zero         in   1  ALU zero flag; sampled in BRANCH
//  mem_ready    in   1  memory handshake: access completes in the cycle it is high
//  pc_en        out  1  PC load enable (unconditional write or taken branch)
//  iord         out  1  memory address select: 0 = PC, 1 = ALUOut
//  mem_read     out  1  memory read strobe
//  mem_write    out  1  memory write strobe
//  ir_write     out  1  IR load enable
//  mem_to_reg   out  1  register-file write data select: 0 = ALUOut, 1 = MDR
//  reg_dst      out  2  destination register: 00 = rt, 01 = rd, 10 = $31
//  reg_write    out  1  register-file write enable
//  alu_src_a    out  1  ALU A select: 0 = PC, 1 = A
//  alu_src_b    out  2  ALU B select: 00 = B, 01 = 4, 10 = imm, 11 = imm<<2
//  alu_op       out  2  ALU op: 00 = add, 01 = sub, 10 = funct, 11 = xor
//  pc_source    out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
//  sign_extend  out  1  1 = sign-extend imm, 0 = zero-extend imm
//  lui          out  1  ALU result = imm<<16
//  state        out  4  current state encoding (debug)
//  instr_done   out  1  one-cycle pulse in the final state of each instruction
//  bus_err      out  1  one-cycle pulse on memory wait timeout
// BEHAVIOUR
//  States: IDLE=0 FETCH=1 DECODE=2 MEM_ADDR=3 MEM_RD=4 MEM_WB=5 MEM_WR=6 R_EXEC=7
//   R_WB=8 BRANCH=9 JUMP=10 I_EXEC=11 I_WB=12 TRAP=13.
//  Outputs are Moore-decoded from state, except pc_en/ir_write/bus_err as noted;
//   unlisted outputs are 0. In IDLE all outputs are 0. IDLE -> FETCH unconditionally.
//  FETCH: mem_read=1, iord=0, alu_src_b=01, alu_op=00, pc_source=00;
//   ir_write=pc_en=mem_ready; stay while !mem_ready; mem_ready -> DECODE.
//  DECODE: alu_src_a=0, alu_src_b=11, sign_extend=1 (branch target into ALUOut). Next state:
//   100011/101011 -> MEM_ADDR; 000000 -> R_EXEC; 001111/001110 -> I_EXEC;
//   000100/000101 -> BRANCH; 000010/000011 -> JUMP; other -> per ILLEGAL_OP_TRAP_EN.
//  MEM_ADDR: alu_src_a=1, alu_src_b=10, sign_extend=1 -> MEM_RD (lw) or MEM_WR (sw).
//  MEM_RD: mem_read=1, iord=1; waits on mem_ready -> MEM_WB.
//  MEM_WB: reg_dst=00, mem_to_reg=1, reg_write=1, instr_done -> FETCH.
//  MEM_WR: mem_write=1, iord=1; waits; instr_done on the mem_ready cycle -> FETCH.
//  R_EXEC: alu_src_a=1, alu_op=10 -> R_WB. R_WB: reg_dst=01, reg_write=1, instr_done -> FETCH.
//  I_EXEC: alu_src_a=1, alu_src_b=10; lui=1 for 001111; alu_op=11, sign_extend=0 for 001110.
//   -> I_WB. I_WB: reg_dst=00, reg_write=1, instr_done -> FETCH.
//  BRANCH: alu_src_a=1, alu_op=01, pc_source=01;
//   pc_en = zero for beq, !zero for bne (opcode latched in DECODE); instr_done -> FETCH.
//  JUMP: pc_source=10, pc_en=1, instr_done. For jal also reg_dst=10, reg_write=1 (PC+4 via
//   ALUOut, mem_to_reg=0). -> FETCH.
//  Wait counter: cleared on entry to each memory state; counts !mem_ready cycles.
//   Reaching MEM_WAIT_MAX: bus_err pulse, strobes drop, no pc/IR/reg write, -> IDLE.
//  mem_ready outside memory states is ignored. Latency: j/jal/branch 3 cycles;
//   R/I/sw 4 cycles; lw 5 cycles (+ memory wait cycles).
//  Asynchronous reset mid-instruction aborts it: state=IDLE, outputs 0, counter 0.
// CONFIGURATION
//  ILLEGAL_OP_TRAP_EN defined: unknown opcode in DECODE -> TRAP; TRAP drives all outputs 0;
//   state reads 13; held until reset.
//  Undefined: unknown opcode -> FETCH as NOP (instr_done pulses in DECODE); TRAP unreachable.
// TESTING
//  reset, release, mem_ready=1, opcode=000000 -> states 0,1,2,7,8,1; reg_dst=01 in R_WB.
//  opcode=100011, mem_ready low 2 cycles in MEM_RD -> MEM_RD held 3 cycles; MEM_WB reg_write=1.
//  opcode=000101, zero=0 -> pc_en=1 in BRANCH; zero=1 -> pc_en=0; both pulse instr_done.
//  opcode=000011 -> JUMP: pc_source=10, reg_dst=10, reg_write=1, pc_en=1.
//  FETCH with mem_ready=0 for 8 cycles -> bus_err pulse, state=0, then FETCH retry.
//  opcode=111111 -> TRAP held (macro on) / next state FETCH (macro off); reset mid-MEM_RD -> state 0.

Source files
------------

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle sequencer (master) and the MIPS datapath (slave).
interface multicycle_control_fsm_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic [1:0] reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       sign_extend;
  logic       lui;
  logic [3:0] state;
  logic       instr_done;
  logic       bus_err;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_source, sign_extend, lui, state,
           instr_done, bus_err
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_source, sign_extend, lui, state,
           instr_done, bus_err
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS sequencer: one state per clock, memory states stall on mem_ready with timeout.
// ILLEGAL_OP_TRAP_EN: unknown opcodes lock into TRAP until reset; otherwise they retire as NOPs.
module multicycle_control_fsm #(
  parameter int MEM_WAIT_MAX = 8
) (
  input logic                      clk,
  input logic                      reset,
  multicycle_control_fsm_if.master bus
);

  localparam int CW = $clog2(MEM_WAIT_MAX + 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EXEC   = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_I_EXEC   = 4'd11,
    S_I_WB     = 4'd12,
    S_TRAP     = 4'd13
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [5:0]    op_q, op_d;
  logic          mem_state;
  logic          timeout;
  logic          op_known;
  state_e        illegal_next;

  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign timeout   = mem_state && !bus.mem_ready && (wait_q == CW'(MEM_WAIT_MAX - 1));

  always_comb begin
    op_known = 1'b0;
    case (bus.opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_LUI, OP_XORI, OP_BEQ, OP_BNE, OP_J, OP_JAL: op_known = 1'b1;
      default: op_known = 1'b0;
    endcase
  end

`ifdef ILLEGAL_OP_TRAP_EN
  assign illegal_next = S_TRAP;
`else
  assign illegal_next = S_FETCH;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      op_q    <= op_d;
    end
  end

  // Leaving a memory state (or any non-memory state) zeroes the counter, so entry always starts at 0.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wait_d  = '0;
    if (mem_state && !bus.mem_ready && !timeout) begin
      wait_d = wait_q + 1'b1;
    end
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (timeout)            state_d = S_IDLE;
        else if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        op_d = bus.opcode;
        if (!op_known) begin
          state_d = illegal_next;
        end else begin
          case (bus.opcode)
            OP_LW, OP_SW:    state_d = S_MEM_ADDR;
            OP_LUI, OP_XORI: state_d = S_I_EXEC;
            OP_BEQ, OP_BNE:  state_d = S_BRANCH;
            OP_J, OP_JAL:    state_d = S_JUMP;
            default:         state_d = S_R_EXEC;
          endcase
        end
      end
      S_MEM_ADDR: state_d = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (timeout)            state_d = S_IDLE;
        else if (bus.mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WR: begin
        if (timeout)            state_d = S_IDLE;
        else if (bus.mem_ready) state_d = S_FETCH;
      end
      S_R_EXEC: state_d = S_R_WB;
      S_I_EXEC: state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
      S_TRAP:   state_d = S_TRAP;
`endif
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.pc_en       = 1'b0;
    bus.iord        = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.ir_write    = 1'b0;
    bus.mem_to_reg  = 1'b0;
    bus.reg_dst     = 2'b00;
    bus.reg_write   = 1'b0;
    bus.alu_src_a   = 1'b0;
    bus.alu_src_b   = 2'b00;
    bus.alu_op      = 2'b00;
    bus.pc_source   = 2'b00;
    bus.sign_extend = 1'b0;
    bus.lui         = 1'b0;
    bus.instr_done  = 1'b0;
    bus.bus_err     = timeout;
    case (state_q)
      S_FETCH: begin
        bus.mem_read  = !timeout;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready;
        bus.pc_en     = bus.mem_ready;
      end
      S_DECODE: begin
        bus.alu_src_b   = 2'b11;
        bus.sign_extend = 1'b1;
`ifndef ILLEGAL_OP_TRAP_EN
        bus.instr_done  = !op_known;
`endif
      end
      S_MEM_ADDR: begin
        bus.alu_src_a   = 1'b1;
        bus.alu_src_b   = 2'b10;
        bus.sign_extend = 1'b1;
      end
      S_MEM_RD: begin
        bus.iord     = 1'b1;
        bus.mem_read = !timeout;
      end
      S_MEM_WB: begin
        bus.mem_to_reg = 1'b1;
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        bus.iord       = 1'b1;
        bus.mem_write  = !timeout;
        bus.instr_done = bus.mem_ready;
      end
      S_R_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
      end
      S_R_WB: begin
        bus.reg_dst    = 2'b01;
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_I_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.lui       = (op_q == OP_LUI);
        bus.alu_op    = (op_q == OP_XORI) ? 2'b11 : 2'b00;
      end
      S_I_WB: begin
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a  = 1'b1;
        bus.alu_op     = 2'b01;
        bus.pc_source  = 2'b01;
        bus.pc_en      = (op_q == OP_BEQ) ? bus.zero : !bus.zero;
        bus.instr_done = 1'b1;
      end
      S_JUMP: begin
        bus.pc_source  = 2'b10;
        bus.pc_en      = 1'b1;
        bus.instr_done = 1'b1;
        if (op_q == OP_JAL) begin
          bus.reg_dst   = 2'b10;
          bus.reg_write = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.state = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed vector bench for the multi-cycle sequencer: per-cycle state and control-word checks.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       sign_extend;
    logic       lui;
    logic       instr_done;
    logic       bus_err;
  } ctrl_t;

  typedef struct {
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic [3:0] st;
    ctrl_t      c;
  } vec_t;

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011, LUI = 6'b001111;
  localparam logic [5:0] XORI = 6'b001110, BEQ = 6'b000100, BNE = 6'b000101;
  localparam logic [5:0] J = 6'b000010, JAL = 6'b000011, BAD = 6'b111111;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs[$];

  ctrl_t C0, C_FETCH, C_FETCH_W, C_DEC, C_DEC_NOP, C_MADDR, C_MRD, C_MWB, C_MWR;
  ctrl_t C_REX, C_RWB, C_IX_X, C_IX_L, C_IWB, C_BR_T, C_BR_N, C_J, C_JAL, C_TO_F, C_TO_R;

  multicycle_control_fsm_if bus_if ();

  multicycle_control_fsm #(.MEM_WAIT_MAX(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  function automatic ctrl_t read_ctrl();
    ctrl_t a;
    a.pc_en       = bus_if.pc_en;
    a.iord        = bus_if.iord;
    a.mem_read    = bus_if.mem_read;
    a.mem_write   = bus_if.mem_write;
    a.ir_write    = bus_if.ir_write;
    a.mem_to_reg  = bus_if.mem_to_reg;
    a.reg_dst     = bus_if.reg_dst;
    a.reg_write   = bus_if.reg_write;
    a.alu_src_a   = bus_if.alu_src_a;
    a.alu_src_b   = bus_if.alu_src_b;
    a.alu_op      = bus_if.alu_op;
    a.pc_source   = bus_if.pc_source;
    a.sign_extend = bus_if.sign_extend;
    a.lui         = bus_if.lui;
    a.instr_done  = bus_if.instr_done;
    a.bus_err     = bus_if.bus_err;
    return a;
  endfunction

  task automatic check_now(input string name, input logic [3:0] est, input ctrl_t ec);
    ctrl_t act;
    act = read_ctrl();
    checks++;
    if (bus_if.state !== est) begin
      failures++;
      $display("FAIL %s state actual=%0d required=%0d", name, bus_if.state, est);
    end
    checks++;
    if (act !== ec) begin
      failures++;
      $display("FAIL %s ctrl actual=%h required=%h", name, act, ec);
    end
  endtask

  task automatic step(input logic [5:0] op, input logic z, input logic mr,
                      input logic [3:0] st, input ctrl_t c, input string name);
    bus_if.opcode    = op;
    bus_if.zero      = z;
    bus_if.mem_ready = mr;
    #1;
    check_now(name, st, c);
    @(negedge clk);
  endtask

  task automatic add(input logic [5:0] op, input logic z, input logic mr,
                     input logic [3:0] st, input ctrl_t c);
    vec_t v;
    v.opcode = op; v.zero = z; v.mem_ready = mr; v.st = st; v.c = c;
    vecs.push_back(v);
  endtask

  task automatic reset_async(input string name);
    #3 reset = 1'b1;
    #1 check_now(name, 4'd0, C0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    C0 = '0;
    C_FETCH_W = '0; C_FETCH_W.mem_read = 1'b1; C_FETCH_W.alu_src_b = 2'b01;
    C_FETCH = C_FETCH_W; C_FETCH.ir_write = 1'b1; C_FETCH.pc_en = 1'b1;
    C_DEC = '0; C_DEC.alu_src_b = 2'b11; C_DEC.sign_extend = 1'b1;
    C_DEC_NOP = C_DEC; C_DEC_NOP.instr_done = 1'b1;
    C_MADDR = '0; C_MADDR.alu_src_a = 1'b1; C_MADDR.alu_src_b = 2'b10; C_MADDR.sign_extend = 1'b1;
    C_MRD = '0; C_MRD.mem_read = 1'b1; C_MRD.iord = 1'b1;
    C_MWB = '0; C_MWB.mem_to_reg = 1'b1; C_MWB.reg_write = 1'b1; C_MWB.instr_done = 1'b1;
    C_MWR = '0; C_MWR.mem_write = 1'b1; C_MWR.iord = 1'b1; C_MWR.instr_done = 1'b1;
    C_REX = '0; C_REX.alu_src_a = 1'b1; C_REX.alu_op = 2'b10;
    C_RWB = '0; C_RWB.reg_dst = 2'b01; C_RWB.reg_write = 1'b1; C_RWB.instr_done = 1'b1;
    C_IX_X = '0; C_IX_X.alu_src_a = 1'b1; C_IX_X.alu_src_b = 2'b10; C_IX_X.alu_op = 2'b11;
    C_IX_L = '0; C_IX_L.alu_src_a = 1'b1; C_IX_L.alu_src_b = 2'b10; C_IX_L.lui = 1'b1;
    C_IWB = '0; C_IWB.reg_write = 1'b1; C_IWB.instr_done = 1'b1;
    C_BR_N = '0; C_BR_N.alu_src_a = 1'b1; C_BR_N.alu_op = 2'b01; C_BR_N.pc_source = 2'b01;
    C_BR_N.instr_done = 1'b1;
    C_BR_T = C_BR_N; C_BR_T.pc_en = 1'b1;
    C_J = '0; C_J.pc_source = 2'b10; C_J.pc_en = 1'b1; C_J.instr_done = 1'b1;
    C_JAL = C_J; C_JAL.reg_dst = 2'b10; C_JAL.reg_write = 1'b1;
    C_TO_F = '0; C_TO_F.alu_src_b = 2'b01; C_TO_F.bus_err = 1'b1;
    C_TO_R = '0; C_TO_R.iord = 1'b1; C_TO_R.bus_err = 1'b1;

    // R-type then lw with two wait cycles
    add(RT, 0, 1, 0, C0);       add(RT, 0, 1, 1, C_FETCH);   add(RT, 0, 1, 2, C_DEC);
    add(RT, 0, 1, 7, C_REX);    add(RT, 0, 1, 8, C_RWB);     add(RT, 0, 1, 1, C_FETCH);
    add(LW, 0, 1, 2, C_DEC);    add(RT, 0, 1, 3, C_MADDR);   add(RT, 0, 0, 4, C_MRD);
    add(RT, 0, 0, 4, C_MRD);    add(RT, 0, 1, 4, C_MRD);     add(RT, 0, 1, 5, C_MWB);
    // bne taken / not taken; opcode input changed after DECODE to prove it is latched
    add(RT, 0, 1, 1, C_FETCH);  add(BNE, 0, 1, 2, C_DEC);    add(BEQ, 0, 1, 9, C_BR_T);
    add(RT, 0, 1, 1, C_FETCH);  add(BNE, 0, 1, 2, C_DEC);    add(BEQ, 1, 1, 9, C_BR_N);
    // jal, sw, xori, lui, j, beq taken
    add(RT, 0, 1, 1, C_FETCH);  add(JAL, 0, 1, 2, C_DEC);    add(RT, 0, 1, 10, C_JAL);
    add(RT, 0, 1, 1, C_FETCH);  add(SW, 0, 1, 2, C_DEC);     add(RT, 0, 0, 3, C_MADDR);
    add(RT, 0, 1, 6, C_MWR);    add(RT, 0, 1, 1, C_FETCH);   add(XORI, 0, 1, 2, C_DEC);
    add(RT, 0, 1, 11, C_IX_X);  add(RT, 0, 1, 12, C_IWB);    add(RT, 0, 1, 1, C_FETCH);
    add(LUI, 0, 1, 2, C_DEC);   add(RT, 0, 1, 11, C_IX_L);   add(RT, 0, 1, 12, C_IWB);
    add(RT, 0, 1, 1, C_FETCH);  add(J, 0, 1, 2, C_DEC);      add(RT, 0, 1, 10, C_J);
    add(RT, 0, 1, 1, C_FETCH);  add(BEQ, 0, 1, 2, C_DEC);    add(BNE, 1, 1, 9, C_BR_T);

    bus_if.opcode = RT; bus_if.zero = 1'b0; bus_if.mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_now("reset", 4'd0, C0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].opcode, vecs[i].zero, vecs[i].mem_ready, vecs[i].st, vecs[i].c,
           $sformatf("vec%0d", i));
    end

    // FETCH stalls 8 cycles: seven plain waits, then the timeout cycle
    for (int k = 0; k < 7; k++) step(RT, 0, 0, 1, C_FETCH_W, $sformatf("fetch_wait%0d", k));
    step(RT, 0, 0, 1, C_TO_F, "fetch_timeout");
    step(RT, 0, 1, 0, C0, "timeout_idle");
    step(RT, 0, 1, 1, C_FETCH, "fetch_retry");

`ifdef ILLEGAL_OP_TRAP_EN
    step(BAD, 0, 1, 2, C_DEC, "illegal_decode");
    for (int k = 0; k < 3; k++) step(RT, 0, 1, 13, C0, $sformatf("trap_hold%0d", k));
`else
    step(BAD, 0, 1, 2, C_DEC_NOP, "illegal_nop");
    step(RT, 0, 1, 1, C_FETCH, "illegal_next_fetch");
`endif
    reset_async("reset_after_illegal");

    step(RT, 0, 1, 0, C0, "r2_idle");
    step(RT, 0, 1, 1, C_FETCH, "r2_fetch");
    step(LW, 0, 1, 2, C_DEC, "r2_decode");
    step(RT, 0, 1, 3, C_MADDR, "r2_maddr");
    step(RT, 0, 0, 4, C_MRD, "r2_mrd0");
    step(RT, 0, 0, 4, C_MRD, "r2_mrd1");
    reset_async("reset_mid_mem_rd");

    // lw read stalls until timeout
    step(RT, 0, 1, 0, C0, "r3_idle");
    step(RT, 0, 1, 1, C_FETCH, "r3_fetch");
    step(LW, 0, 1, 2, C_DEC, "r3_decode");
    step(RT, 0, 1, 3, C_MADDR, "r3_maddr");
    for (int k = 0; k < 7; k++) step(RT, 0, 0, 4, C_MRD, $sformatf("rd_wait%0d", k));
    step(RT, 0, 0, 4, C_TO_R, "rd_timeout");
    step(RT, 0, 1, 0, C0, "rd_timeout_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
